// File: rtl/huffman_pqueue_if.sv
// Command and status bundle between the Huffman tree builder and its priority queue.
interface huffman_pqueue_if #(
  parameter int unsigned SYM_W  = 8,
  parameter int unsigned FREQ_W = 32,
  parameter int unsigned CNT_W  = 3
);
  logic              flush;
  logic              ins_en;
  logic [SYM_W-1:0]  ins_sym;
  logic [FREQ_W-1:0] ins_freq;
  logic              ins_node;
  logic              pop_en;
  logic              head_valid;
  logic [SYM_W-1:0]  head_sym;
  logic [FREQ_W-1:0] head_freq;
  logic              head_node;
  logic              sec_valid;
  logic [SYM_W-1:0]  sec_sym;
  logic [FREQ_W-1:0] sec_freq;
  logic              sec_node;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, ins_en, ins_sym, ins_freq, ins_node, pop_en,
    input  head_valid, head_sym, head_freq, head_node,
    input  sec_valid, sec_sym, sec_freq, sec_node,
    input  count, full, empty, overflow, underflow
  );

  modport slave (
    input  flush, ins_en, ins_sym, ins_freq, ins_node, pop_en,
    output head_valid, head_sym, head_freq, head_node,
    output sec_valid, sec_sym, sec_freq, sec_node,
    output count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/huffman_pqueue.sv
// Self-sorting priority queue (ascending freq, FIFO on ties) with insert, pop-min
// and combined pop+insert for the Huffman merge step.
module huffman_pqueue #(
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned SYM_W  = 8,
  parameter int unsigned FREQ_W = 32,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             ctrl_reset,
  huffman_pqueue_if.slave bus
);
  logic [DEPTH-1:0]  v_q;
  logic [SYM_W-1:0]  s_q [DEPTH];
  logic [FREQ_W-1:0] f_q [DEPTH];
  logic [DEPTH-1:0]  n_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              full_q, empty_q, ovf_q, udf_q;

  logic [DEPTH-1:0]  b_v, nx_v;
  logic [SYM_W-1:0]  b_s [DEPTH];
  logic [SYM_W-1:0]  nx_s [DEPTH];
  logic [FREQ_W-1:0] b_f [DEPTH];
  logic [FREQ_W-1:0] nx_f [DEPTH];
  logic [DEPTH-1:0]  b_n, nx_n;
  logic [CNT_W-1:0]  base_cnt, pos, nx_cnt;
  logic              do_pop, do_ins, nx_ovf, nx_udf;

  // Pop shifts the array down first; the insert then lands in that shifted view.
  always_comb begin
    do_pop   = bus.pop_en && !empty_q;
    do_ins   = bus.ins_en && (do_pop || !full_q);
    base_cnt = cnt_q - CNT_W'(do_pop);
    b_v = v_q;
    b_n = n_q;
    for (int i = 0; i < DEPTH; i++) begin
      b_s[i] = s_q[i];
      b_f[i] = f_q[i];
    end
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        b_v[i] = v_q[i+1];
        b_s[i] = s_q[i+1];
        b_f[i] = f_q[i+1];
        b_n[i] = n_q[i+1];
      end
      b_v[DEPTH-1] = 1'b0;
      b_s[DEPTH-1] = '0;
      b_f[DEPTH-1] = '0;
      b_n[DEPTH-1] = 1'b0;
    end

    // Strict '>' places a new entry after all equal frequencies.
    pos = base_cnt;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (b_v[i] && (b_f[i] > bus.ins_freq)) pos = CNT_W'(i);
    end

    nx_v = b_v;
    nx_n = b_n;
    for (int i = 0; i < DEPTH; i++) begin
      nx_s[i] = b_s[i];
      nx_f[i] = b_f[i];
    end
    if (do_ins) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (CNT_W'(i) > pos) begin
          nx_v[i] = b_v[i-1];
          nx_s[i] = b_s[i-1];
          nx_f[i] = b_f[i-1];
          nx_n[i] = b_n[i-1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == pos) begin
          nx_v[i] = 1'b1;
          nx_s[i] = bus.ins_sym;
          nx_f[i] = bus.ins_freq;
          nx_n[i] = bus.ins_node;
        end
      end
    end
    nx_cnt = base_cnt + CNT_W'(do_ins);
    nx_ovf = ovf_q || (bus.ins_en && !bus.pop_en && full_q);
    nx_udf = udf_q || (bus.pop_en && empty_q);

    if (bus.flush) begin
      nx_v = '0;
      nx_n = '0;
      for (int i = 0; i < DEPTH; i++) begin
        nx_s[i] = '0;
        nx_f[i] = '0;
      end
      nx_cnt = '0;
      nx_ovf = 1'b0;
      nx_udf = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      v_q <= '0;
      n_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= '0;
        f_q[i] <= '0;
      end
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      v_q <= nx_v;
      n_q <= nx_n;
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= nx_s[i];
        f_q[i] <= nx_f[i];
      end
      cnt_q   <= nx_cnt;
      full_q  <= (nx_cnt == CNT_W'(DEPTH));
      empty_q <= (nx_cnt == '0);
      ovf_q   <= nx_ovf;
      udf_q   <= nx_udf;
    end
  end

  assign bus.head_valid = v_q[0];
  assign bus.head_sym   = s_q[0];
  assign bus.head_freq  = f_q[0];
  assign bus.head_node  = n_q[0];
  assign bus.sec_valid  = v_q[1];
  assign bus.sec_sym    = s_q[1];
  assign bus.sec_freq   = f_q[1];
  assign bus.sec_node   = n_q[1];
  assign bus.count      = cnt_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;
endmodule

// File: tb/tb_huffman_pqueue.sv
// Directed bench for huffman_pqueue: ordering, merge step, boundaries, reset and flush.
module tb_huffman_pqueue;
  localparam int unsigned DEPTH  = 6;
  localparam int unsigned SYM_W  = 8;
  localparam int unsigned FREQ_W = 32;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic ctrl_reset;
  int   checks = 0;
  int   errors = 0;

  huffman_pqueue_if #(.SYM_W(SYM_W), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) bus ();

  huffman_pqueue #(.DEPTH(DEPTH), .SYM_W(SYM_W), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .ctrl_reset(ctrl_reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command per cycle; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic ins, input logic [SYM_W-1:0] sym, input logic [FREQ_W-1:0] freq,
                     input logic node, input logic pop, input logic fl);
    bus.ins_en   = ins;
    bus.ins_sym  = sym;
    bus.ins_freq = freq;
    bus.ins_node = node;
    bus.pop_en   = pop;
    bus.flush    = fl;
    @(posedge clk);
    #1;
    bus.ins_en = 1'b0;
    bus.pop_en = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic ins(input logic [SYM_W-1:0] sym, input logic [FREQ_W-1:0] freq);
    cyc(1'b1, sym, freq, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    ctrl_reset   = 1'b1;
    bus.flush    = 1'b0;
    bus.ins_en   = 1'b0;
    bus.ins_sym  = '0;
    bus.ins_freq = '0;
    bus.ins_node = 1'b0;
    bus.pop_en   = 1'b0;
    #2;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_head_valid", 64'(bus.head_valid), 64'd0);
    @(negedge clk);
    ctrl_reset = 1'b0;
    @(posedge clk);
    #1;

    // Insert order and pops
    ins("A", 5); ins("B", 2); ins("C", 9); ins("D", 2);
    chk("ord_head_sym", 64'(bus.head_sym), 64'h42);
    chk("ord_head_freq", 64'(bus.head_freq), 64'd2);
    chk("ord_sec_sym", 64'(bus.sec_sym), 64'h44);
    chk("ord_sec_freq", 64'(bus.sec_freq), 64'd2);
    chk("ord_count", 64'(bus.count), 64'd4);
    pop(); chk("pop1_head", 64'(bus.head_sym), 64'h44);
    pop(); chk("pop2_head", 64'(bus.head_sym), 64'h41);
    pop(); chk("pop3_head", 64'(bus.head_sym), 64'h43);
    pop(); chk("pop4_empty", 64'(bus.empty), 64'd1);
    chk("pop4_count", 64'(bus.count), 64'd0);

    // Huffman merge
    ins("B", 2); ins("D", 2); ins("A", 5);
    pop();
    cyc(1'b1, 8'h80, 4, 1'b1, 1'b1, 1'b0);
    chk("merge_head_sym", 64'(bus.head_sym), 64'h80);
    chk("merge_head_freq", 64'(bus.head_freq), 64'd4);
    chk("merge_head_node", 64'(bus.head_node), 64'd1);
    chk("merge_sec_sym", 64'(bus.sec_sym), 64'h41);
    chk("merge_sec_freq", 64'(bus.sec_freq), 64'd5);
    chk("merge_count", 64'(bus.count), 64'd2);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("flush1_count", 64'(bus.count), 64'd0);

    // Full boundary
    for (int i = 1; i <= 6; i++) ins(8'(i), 32'(i));
    chk("full_flag", 64'(bus.full), 64'd1);
    ins(8'h20, 0);
    chk("ovf_flag", 64'(bus.overflow), 64'd1);
    chk("ovf_count", 64'(bus.count), 64'd6);
    chk("ovf_head_freq", 64'(bus.head_freq), 64'd1);
    cyc(1'b1, 8'h10, 0, 1'b0, 1'b1, 1'b0);
    chk("fpi_head_freq", 64'(bus.head_freq), 64'd0);
    chk("fpi_sec_freq", 64'(bus.sec_freq), 64'd2);
    chk("fpi_count", 64'(bus.count), 64'd6);
    chk("fpi_full", 64'(bus.full), 64'd1);

    // Empty boundary
    for (int i = 0; i < 6; i++) pop();
    chk("drain_empty", 64'(bus.empty), 64'd1);
    chk("drain_udf", 64'(bus.underflow), 64'd0);
    pop();
    chk("udf_flag", 64'(bus.underflow), 64'd1);
    chk("udf_count", 64'(bus.count), 64'd0);
    cyc(1'b1, "E", 7, 1'b0, 1'b1, 1'b0);
    chk("epi_count", 64'(bus.count), 64'd1);
    chk("epi_head_sym", 64'(bus.head_sym), 64'h45);
    chk("epi_head_freq", 64'(bus.head_freq), 64'd7);
    chk("epi_udf", 64'(bus.underflow), 64'd1);
    chk("epi_ovf", 64'(bus.overflow), 64'd1);

    // Flush beats a concurrent insert and clears sticky flags
    cyc(1'b1, 8'h09, 1, 1'b0, 1'b0, 1'b1);
    chk("fl_count", 64'(bus.count), 64'd0);
    chk("fl_ovf", 64'(bus.overflow), 64'd0);
    chk("fl_udf", 64'(bus.underflow), 64'd0);
    chk("fl_head_valid", 64'(bus.head_valid), 64'd0);

    // Tie FIFO
    ins("X", 3); ins("Y", 3); ins("Z", 3);
    chk("tie_head", 64'(bus.head_sym), 64'h58);
    chk("tie_sec", 64'(bus.sec_sym), 64'h59);
    pop(); chk("tie_pop1", 64'(bus.head_sym), 64'h59);
    pop(); chk("tie_pop2", 64'(bus.head_sym), 64'h5A);
    pop(); chk("tie_empty", 64'(bus.empty), 64'd1);
    ins("X", 3); ins("Y", 3);
    cyc(1'b1, "W", 3, 1'b0, 1'b1, 1'b0);
    chk("tpi_head", 64'(bus.head_sym), 64'h59);
    chk("tpi_sec", 64'(bus.sec_sym), 64'h57);
    pop(); chk("tpi_pop", 64'(bus.head_sym), 64'h57);
    pop();

    // Reset mid-operation
    ins(1, 4); ins(2, 3); ins(3, 2); ins(4, 1);
    chk("mr_count_pre", 64'(bus.count), 64'd4);
    bus.ins_en   = 1'b1;
    bus.ins_sym  = 8'h33;
    bus.ins_freq = 32'd8;
    #2;
    ctrl_reset = 1'b1;
    #1;
    chk("mr_count", 64'(bus.count), 64'd0);
    chk("mr_empty", 64'(bus.empty), 64'd1);
    chk("mr_full", 64'(bus.full), 64'd0);
    chk("mr_head_valid", 64'(bus.head_valid), 64'd0);
    chk("mr_sec_valid", 64'(bus.sec_valid), 64'd0);
    chk("mr_head_freq", 64'(bus.head_freq), 64'd0);
    @(posedge clk);
    #1;
    chk("mr_held_count", 64'(bus.count), 64'd0);
    bus.ins_en = 1'b0;
    @(negedge clk);
    ctrl_reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_idle_count", 64'(bus.count), 64'd0);
    ins(8'h77, 6);
    chk("mr_ins_count", 64'(bus.count), 64'd1);
    chk("mr_ins_head", 64'(bus.head_sym), 64'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
